// File: rtl/cache_fill_arbiter.sv
// Shared miss-handling controller for the I-cache and D-cache. It arbitrates write-through
// stores and block misses onto one memory port and sequences 8-word block fills.
module cache_fill_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int IDX_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              i_stall,
  output logic              d_stall,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_tag_we,
  output logic              d_tag_we
);

  typedef enum logic       {S_IDLE, S_FILL} state_t;
  typedef enum logic [1:0] {G_NONE, G_I, G_D} grant_t;

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLK - 1);
  localparam logic [IDX_W:0]    LAST_IDX = (IDX_W + 1)'(WORDS_PER_BLK - 1);
  localparam logic [IDX_W:0]    CNT_ONE  = (IDX_W + 1)'(1);

  state_t            r_state,     w_state_nx;
  grant_t            r_grant,     w_grant_nx;
  logic              r_rr_last_d, w_rr_last_d_nx;
  logic [IDX_W:0]    r_issue_cnt, w_issue_nx;
  logic [IDX_W:0]    r_ret_cnt,   w_ret_nx;
  logic [ADDR_W-1:0] r_base,      w_base_nx;
  logic              w_wr_serve;
  logic              w_pick_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_grant     <= G_NONE;
      r_rr_last_d <= 1'b0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_base      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_grant     <= w_grant_nx;
      r_rr_last_d <= w_rr_last_d_nx;
      r_issue_cnt <= w_issue_nx;
      r_ret_cnt   <= w_ret_nx;
      r_base      <= w_base_nx;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nx     = r_state;
    w_grant_nx     = r_grant;
    w_rr_last_d_nx = r_rr_last_d;
    w_issue_nx     = r_issue_cnt;
    w_ret_nx       = r_ret_cnt;
    w_base_nx      = r_base;
    mem_en         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    i_fill_we      = 1'b0;
    d_fill_we      = 1'b0;
    fill_idx       = '0;
    i_tag_we       = 1'b0;
    d_tag_we       = 1'b0;

    w_wr_serve = (r_state == S_IDLE) && d_wr_req && !d_miss;
    // On a tie the cache that did not win the previous tie is chosen.
    w_pick_d   = d_miss && (!i_miss || !r_rr_last_d);

    case (r_state)
      S_IDLE: begin
        if (w_wr_serve) begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = d_wr_addr;
          mem_wdata = d_wr_data;
        end else if (i_miss || d_miss) begin
          w_grant_nx = w_pick_d ? G_D : G_I;
          w_base_nx  = (w_pick_d ? d_miss_addr : i_miss_addr) & BLK_MASK;
          if (i_miss && d_miss) w_rr_last_d_nx = w_pick_d;
          w_state_nx = S_FILL;
        end
      end
      S_FILL: begin
        if (!r_issue_cnt[IDX_W]) begin
          mem_en     = 1'b1;
          mem_addr   = r_base + ADDR_W'({r_issue_cnt[IDX_W-1:0], 1'b0});
          w_issue_nx = r_issue_cnt + CNT_ONE;
        end
        if (mem_rdata_valid) begin
          i_fill_we = (r_grant == G_I);
          d_fill_we = (r_grant == G_D);
          fill_idx  = r_ret_cnt[IDX_W-1:0];
          w_ret_nx  = r_ret_cnt + CNT_ONE;
          if (r_ret_cnt == LAST_IDX) begin
            i_tag_we   = (r_grant == G_I);
            d_tag_we   = (r_grant == G_D);
            w_issue_nx = '0;
            w_ret_nx   = '0;
            w_grant_nx = G_NONE;
            w_state_nx = S_IDLE;
          end
        end
      end
    endcase

    i_stall   = i_miss || (r_state == S_FILL && r_grant == G_I);
    d_stall   = d_miss || (r_state == S_FILL && r_grant == G_D) || (d_wr_req && !w_wr_serve);
    fill_data = mem_rdata;

    // Outputs are forced quiet for as long as reset is held.
    if (!rst) begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_stall   = 1'b0;
      d_stall   = 1'b0;
      i_fill_we = 1'b0;
      d_fill_we = 1'b0;
      fill_idx  = '0;
      fill_data = '0;
      i_tag_we  = 1'b0;
      d_tag_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency (4 cycle) memory model
// that returns addr ^ 16'hA5A5 for every read.
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req, mem_rdata_valid;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data, mem_rdata;
  logic        mem_en, mem_wr, i_stall, d_stall, i_fill_we, d_fill_we, i_tag_we, d_tag_we;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit          hist_v [0:1023];
  logic [15:0] hist_a [0:1023];

  cache_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_stall(i_stall), .d_stall(d_stall),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .fill_idx(fill_idx), .fill_data(fill_data),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rdata_of(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Record this cycle's memory request, advance one clock, then drive the
  // return for the read issued four cycles earlier.
  task automatic step();
    hist_v[cyc] = mem_en && !mem_wr;
    hist_a[cyc] = mem_addr;
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata_valid = (cyc >= 4) ? hist_v[cyc-4] : 1'b0;
    mem_rdata       = (cyc >= 4) ? rdata_of(hist_a[cyc-4]) : 16'h0000;
  endtask

  // Called in T0 (IDLE, miss asserted). Walks T1..T12, drops the granted miss,
  // and ends in T13 which is again an IDLE cycle.
  task automatic do_fill(input bit is_d, input logic [15:0] base, input int wr_at);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == wr_at) begin
        d_wr_req  = 1'b1;
        d_wr_addr = 16'h0100;
        d_wr_data = 16'h1111;
      end
      #1;
      check("rd_en", mem_en, k <= 8);
      if (k <= 8) begin
        check("rd_wr", mem_wr, 1'b0);
        check("rd_addr", mem_addr, base + 16'(2 * (k - 1)));
      end
      check("i_fill_we", i_fill_we, (k >= 5) && !is_d);
      check("d_fill_we", d_fill_we, (k >= 5) && is_d);
      if (k >= 5) begin
        check("fill_idx", fill_idx, k - 5);
        check("fill_data", fill_data, rdata_of(base + 16'(2 * (k - 5))));
      end
      check("i_tag_we", i_tag_we, (k == 12) && !is_d);
      check("d_tag_we", d_tag_we, (k == 12) && is_d);
      check("i_stall_fill", i_stall, i_miss || !is_d);
      check("d_stall_fill", d_stall, d_miss || is_d || d_wr_req);
    end
    if (is_d) d_miss = 1'b0;
    else      i_miss = 1'b0;
    step();
    #1;
    if (is_d) check("d_stall_end", d_stall, 1'b0);
    else      check("i_stall_end", i_stall, 1'b0);
    check("idle_en", mem_en, d_wr_req && !d_miss);
  endtask

  initial begin
    rst = 1'b0;
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    d_miss = 1'b0; d_miss_addr = 16'h0000;
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    mem_rdata_valid = 1'b1; mem_rdata = 16'h5555;
    #3;
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_i_stall", i_stall, 1'b0);
    check("rst_d_stall", d_stall, 1'b0);
    check("rst_fill_we", i_fill_we, 1'b0);
    check("rst_fill_data", fill_data, 16'h0000);
    i_miss = 1'b0; d_wr_req = 1'b0; mem_rdata_valid = 1'b0;
    #4 rst = 1'b1;
    step(); step();

    // I-miss at 0x1234: reads 0x1230..0x123E, fills T5..T12.
    i_miss = 1'b1; i_miss_addr = 16'h1234; #1;
    check("t0_i_stall", i_stall, 1'b1);
    check("t0_mem_en", mem_en, 1'b0);
    do_fill(1'b0, 16'h1230, 0);
    step(); step();

    // Tie after reset: D first, then I.
    i_miss = 1'b1; i_miss_addr = 16'h1F07;
    d_miss = 1'b1; d_miss_addr = 16'h8ABC; #1;
    do_fill(1'b1, 16'h8AB0, 0);
    do_fill(1'b0, 16'h1F00, 0);
    step();

    // Second tie: I wins this time.
    i_miss = 1'b1; i_miss_addr = 16'h0203;
    d_miss = 1'b1; d_miss_addr = 16'hFFF9; #1;
    do_fill(1'b0, 16'h0200, 0);
    do_fill(1'b1, 16'hFFF0, 0);
    step();

    // Store plus I-miss in the same IDLE cycle: store goes first.
    i_miss = 1'b1; i_miss_addr = 16'h3000;
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; #1;
    check("st_en", mem_en, 1'b1);
    check("st_wr", mem_wr, 1'b1);
    check("st_addr", mem_addr, 16'h0040);
    check("st_wdata", mem_wdata, 16'hBEEF);
    check("st_d_stall", d_stall, 1'b0);
    check("st_i_stall", i_stall, 1'b1);
    step();
    d_wr_req = 1'b0; #1;
    do_fill(1'b0, 16'h3000, 0);
    step();

    // Store arriving during an I fill waits for the first IDLE cycle.
    i_miss = 1'b1; i_miss_addr = 16'h2008; #1;
    do_fill(1'b0, 16'h2000, 3);
    check("late_st_wr", mem_wr, 1'b1);
    check("late_st_addr", mem_addr, 16'h0100);
    check("late_st_wdata", mem_wdata, 16'h1111);
    check("late_st_d_stall", d_stall, 1'b0);
    step();
    d_wr_req = 1'b0;

    // Reset in T6 of a fill.
    i_miss = 1'b1; i_miss_addr = 16'h4444; #1;
    for (int k = 1; k <= 6; k++) step();
    #1;
    check("pre_rst_fill_we", i_fill_we, 1'b1);
    check("pre_rst_fill_idx", fill_idx, 3'd1);
    rst = 1'b0; #1;
    check("ab_fill_we", i_fill_we, 1'b0);
    check("ab_mem_en", mem_en, 1'b0);
    check("ab_i_stall", i_stall, 1'b0);
    check("ab_tag_we", i_tag_we, 1'b0);
    i_miss = 1'b0;
    step(); step();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(); #1;
      check("stale_ret_quiet", {i_fill_we, d_fill_we, i_tag_we, d_tag_we}, 4'b0000);
    end

    // Stray valid pulse in IDLE is ignored.
    mem_rdata_valid = 1'b1; mem_rdata = 16'hDEAD; #1;
    check("idle_valid_fill", {i_fill_we, d_fill_we}, 2'b00);
    check("idle_valid_tag", {i_tag_we, d_tag_we}, 2'b00);
    step();
    i_miss = 1'b1; i_miss_addr = 16'h5557; #1;
    do_fill(1'b0, 16'h5550, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
